// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instruction requests into 32-bit MIPS words
// and queues them in a small circular FIFO feeding the fetch/decode path.
// Optional feature macro: INSTR_ENC_PSEUDO_LI_EN enables expansion of the
// `li` pseudo-op (op 4) into a lui/ori pair through the EXPAND state. When the
// macro is undefined, op 4 is treated as an illegal request.
//
// Handshake semantics (both ports): a transfer happens on the rising edge
// where valid && ready are both high. ready never depends on valid; the
// producer holds its payload stable until that edge, and out_instr is held
// stable while out_valid && !out_ready.

module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [5:0]                 in_funct,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic                       err_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_R   = 3'd0;
  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_BEQ = 3'd3;
`ifdef INSTR_ENC_PSEUDO_LI_EN
  localparam logic [2:0] OP_LI  = 3'd4;
`endif

`ifdef INSTR_ENC_PSEUDO_LI_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_EXPAND = 1'b1} state_t;
`else
  typedef enum logic {ST_IDLE = 1'b0} state_t;
`endif

  // FSM state is a plainly named register so checkers can bind to it.
  state_t state, state_n;

  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push, pop;
  logic [31:0]   push_word;
  logic          set_err;

`ifdef INSTR_ENC_PSEUDO_LI_EN
  logic [31:0] ori_q;
  logic        latch_ori;
  logic [31:0] ori_word;
  assign ori_word = {6'b001101, in_rt, in_rt, in_imm[15:0]};
`else
  // Upper immediate bits only matter for the li expansion.
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:16];
`endif

  assign full        = (count == CW'(DEPTH));
  assign out_valid   = (count != '0);
  assign out_count   = count;
  assign out_instr   = mem[rd_ptr];
  assign pop         = out_valid && out_ready;

  // Next-state, handshake and push decode; pushes only ever happen when not full.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    push      = 1'b0;
    push_word = '0;
    set_err   = 1'b0;
`ifdef INSTR_ENC_PSEUDO_LI_EN
    latch_ori = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        in_ready = !full;
        if (in_valid && !full) begin
          case (in_op)
            OP_R: begin
              push      = 1'b1;
              push_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            end
            OP_LW: begin
              push      = 1'b1;
              push_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            end
            OP_SW: begin
              push      = 1'b1;
              push_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            end
            OP_BEQ: begin
              push      = 1'b1;
              push_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            end
`ifdef INSTR_ENC_PSEUDO_LI_EN
            OP_LI: begin
              push      = 1'b1;
              push_word = {6'b001111, 5'b00000, in_rt, in_imm[31:16]};
              latch_ori = 1'b1;
              state_n   = ST_EXPAND;
            end
`endif
            default: set_err = 1'b1;
          endcase
        end
      end
`ifdef INSTR_ENC_PSEUDO_LI_EN
      ST_EXPAND: begin
        // Request side is closed until the ori half is queued.
        if (!full) begin
          push      = 1'b1;
          push_word = ori_q;
          state_n   = ST_IDLE;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

`ifdef INSTR_ENC_PSEUDO_LI_EN
  // Holds the ori half of an li until EXPAND can push it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ori_q <= '0;
    else if (latch_ori) ori_q <= ori_word;
  end
`endif

  // FIFO storage; cleared on reset so the empty head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count + CW'(push) - CW'(pop);
  end

  // Sticky illegal-request flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_illegal <= 1'b0;
    else if (set_err) err_illegal <= 1'b1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder. Inputs change just after the falling
// edge and outputs are checked on the following falling edge.
// Follows INSTR_ENC_PSEUDO_LI_EN the same way as the design.

module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [5:0]    in_funct = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [CW-1:0] out_count;
  logic          err_illegal;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_count(out_count),
    .err_illegal(err_illegal)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_req(input logic [2:0] op, input logic [5:0] funct,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] imm);
    in_valid = 1'b1;
    in_op = op; in_funct = funct;
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  task automatic idle_req();
    in_valid = 1'b0;
    in_op = '0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_req();
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", out_instr); end
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    out_ready = 1'b1;
    drive_req(3'd0, 6'h20, 5'd1, 5'd2, 5'd3, 32'h0);
    @(negedge clk);
    idle_req();
    checks++; if (out_instr !== 32'h00221820) begin failures++; $display("FAIL rtype_word got=%h exp=00221820", out_instr); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rtype_valid got=%b exp=1", out_valid); end
    checks++; if (out_count !== 3'd1) begin failures++; $display("FAIL rtype_count1 got=%0d exp=1", out_count); end
    @(negedge clk);
    checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL rtype_count0 got=%0d exp=0", out_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rtype_empty got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    exp_q = {32'h8C850010, 32'hAC85FFFC, 32'h10220003};
    drive_req(3'd1, 6'h0, 5'd4, 5'd5, 5'd0, 32'h0000_0010);
    @(negedge clk);
    drive_req(3'd2, 6'h0, 5'd4, 5'd5, 5'd0, 32'h0000_FFFC);
    @(negedge clk);
    drive_req(3'd3, 6'h0, 5'd1, 5'd2, 5'd0, 32'h0000_0003);
    @(negedge clk);
    idle_req();
    checks++; if (out_count !== 3'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", out_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_instr !== exp_q[0]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, out_instr, exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_li();
    out_ready = 1'b0;
    drive_req(3'd4, 6'h0, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    @(negedge clk);
    idle_req();
`ifdef INSTR_ENC_PSEUDO_LI_EN
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL li_expand_ready got=%b exp=0", in_ready); end
    checks++; if (out_instr !== 32'h3C081234) begin failures++; $display("FAIL li_lui got=%h exp=3C081234", out_instr); end
    checks++; if (out_count !== 3'd1) begin failures++; $display("FAIL li_count1 got=%0d exp=1", out_count); end
    @(negedge clk);
    checks++; if (out_count !== 3'd2) begin failures++; $display("FAIL li_count2 got=%0d exp=2", out_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL li_ready_back got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_instr !== 32'h35085678) begin failures++; $display("FAIL li_ori got=%h exp=35085678", out_instr); end
    @(negedge clk);
    checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL li_drained got=%0d exp=0", out_count); end
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL li_err got=%b exp=0", err_illegal); end
    out_ready = 1'b0;
`else
    checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL li_off_count got=%0d exp=0", out_count); end
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL li_off_err got=%b exp=1", err_illegal); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL li_off_ready got=%b exp=1", in_ready); end
    apply_reset();
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] words [5];
    int accepted = 0;
    words = '{32'h00220820, 32'h00221020, 32'h00221820, 32'h00222020, 32'h00222820};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_req(3'd0, 6'h20, 5'd1, 5'd2, 5'(accepted + 1), 32'h0);
      #1;
      if (in_ready) accepted++;
      @(negedge clk);
      if (accepted > 0) begin
        checks++;
        if (out_instr !== words[0]) begin failures++; $display("FAIL bp_head_stable%0d got=%h exp=%h", i, out_instr, words[0]); end
      end
    end
    idle_req();
    checks++; if (accepted !== 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", accepted); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
    checks++; if (out_count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", out_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_instr !== words[i]) begin failures++; $display("FAIL bp_drain%0d got=%h exp=%h", i, out_instr, words[i]); end
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
      end
    end
    checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL bp_drained got=%0d exp=0", out_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    drive_req(3'd0, 6'h22, 5'd7, 5'd8, 5'd9, 32'h0);
    @(negedge clk);
    drive_req(3'd6, 6'h0, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    idle_req();
    checks++; if (out_count !== 3'd1) begin failures++; $display("FAIL ill_count got=%0d exp=1", out_count); end
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", err_illegal); end
    checks++; if (out_instr !== 32'h00E84822) begin failures++; $display("FAIL ill_head got=%h exp=00E84822", out_instr); end
    repeat (3) @(negedge clk);
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL ill_sticky got=%b exp=1", err_illegal); end
    rst_n = 1'b0;
    #1;
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL ill_cleared got=%b exp=0", err_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_expand();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(3'd0, 6'h20, 5'd1, 5'd2, 5'(i + 1), 32'h0);
      @(negedge clk);
    end
`ifdef INSTR_ENC_PSEUDO_LI_EN
    drive_req(3'd4, 6'h0, 5'd0, 5'd8, 5'd0, 32'h1234_5678);
    @(negedge clk);
    idle_req();
    @(negedge clk);
    checks++; if (out_count !== 3'd4) begin failures++; $display("FAIL rx_full got=%0d exp=4", out_count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rx_stall got=%b exp=0", in_ready); end
`else
    drive_req(3'd0, 6'h20, 5'd1, 5'd2, 5'd4, 32'h0);
    @(negedge clk);
    idle_req();
    checks++; if (out_count !== 3'd4) begin failures++; $display("FAIL rx_full got=%0d exp=4", out_count); end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_count !== 3'd0) begin failures++; $display("FAIL rx_count got=%0d exp=0", out_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rx_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rx_no_ori%0d got=%b instr=%h exp=0", i, out_valid, out_instr); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rx_ready got=%b exp=1", in_ready); end
    out_ready = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report
  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_li();
    test_backpressure();
    test_illegal();
    test_reset_expand();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
